kernel_window: RTL and testbench

Streaming sliding-window generator for the HOG pipeline. It accepts one column of `BLOCK_HEIGHT` vertically aligned pixels per handshake, typically from the line buffers. It emits a full `BLOCK_WIDTH x BLOCK_HEIGHT` window through a single registered valid/ready port. Over the per-row shift-register kernel it adds a single shared handshake, row-end flushing, configurable horizontal stride and full backpressure support.

---
 rtl/kernel_window.sv | 150 +++++++++++++++
 tb/tb_kernel_window.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_window.sv
// kernel_window: streaming sliding-window generator.
// Accepts one column of BLOCK_HEIGHT pixels per handshake. Emits a BLOCK_WIDTH x BLOCK_HEIGHT
// window through a registered valid/ready port, with horizontal stride and row-end flushing.
// Optional feature: define KERNEL_WINDOW_COL_EN to add the out_col port and column counter.
module kernel_window #(
  parameter int unsigned BLOCK_WIDTH  = 3,
  parameter int unsigned BLOCK_HEIGHT = 3,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STRIDE       = 1,
  parameter int unsigned COL_WIDTH    = 10
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [DATA_WIDTH*BLOCK_HEIGHT-1:0]          in_pixels,
  input  logic                                        in_valid,
  input  logic                                        in_last,
  output logic                                        in_ready,
  output logic [BLOCK_WIDTH*BLOCK_HEIGHT*DATA_WIDTH-1:0] out_pixels,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        out_last
`ifdef KERNEL_WINDOW_COL_EN
  ,
  output logic [COL_WIDTH-1:0]                        out_col
`endif
);

  localparam int unsigned ColBits = DATA_WIDTH * BLOCK_HEIGHT;
  localparam int unsigned WinBits = BLOCK_WIDTH * BLOCK_HEIGHT * DATA_WIDTH;
  localparam int unsigned FillW   = $clog2(BLOCK_WIDTH + 1);
  localparam int unsigned PhaseW  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [FillW-1:0]  FillFull  = FillW'(BLOCK_WIDTH);
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(STRIDE - 1);

  logic [BLOCK_WIDTH-1:0][ColBits-1:0] col_q, col_d;
  logic [FillW-1:0]                    fill_q, fill_d;
  logic [PhaseW-1:0]                   phase_q, phase_d;
  logic [WinBits-1:0]                  out_pixels_q, out_pixels_d;
  logic                                out_valid_q, out_valid_d;
  logic                                out_last_q, out_last_d;
  logic [WinBits-1:0]                  win;
  logic                                accept;
  logic                                emit;

  // Input is stalled only while a window is held and downstream refuses it.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next state: column shift, fill/phase tracking and emit decision.
  always_comb begin
    col_d   = col_q;
    fill_d  = fill_q;
    phase_d = phase_q;
    emit    = 1'b0;
    if (accept) begin
      for (int c = 0; c < int'(BLOCK_WIDTH) - 1; c++) begin
        col_d[c] = col_q[c+1];
      end
      col_d[BLOCK_WIDTH-1] = in_pixels;
      fill_d = (fill_q == FillFull) ? FillFull : fill_q + 1'b1;
      if (fill_d == FillFull) begin
        emit    = (phase_q == '0);
        phase_d = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
      end
      // Row end flushes after this beat's own emit decision.
      if (in_last) begin
        fill_d  = '0;
        phase_d = '0;
      end
    end
  end

  // Window view of the post-shift column store: pixel (r,c) from column c, row r.
  always_comb begin
    win = '0;
    for (int r = 0; r < int'(BLOCK_HEIGHT); r++) begin
      for (int c = 0; c < int'(BLOCK_WIDTH); c++) begin
        win[(r*BLOCK_WIDTH+c)*DATA_WIDTH +: DATA_WIDTH] = col_d[c][r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output register: load on emit, release on downstream accept, otherwise hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_pixels_d = out_pixels_q;
    out_last_d   = out_last_q;
    if (emit) begin
      out_valid_d  = 1'b1;
      out_pixels_d = win;
      out_last_d   = in_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      fill_q       <= '0;
      phase_q      <= '0;
      out_valid_q  <= 1'b0;
      out_pixels_q <= '0;
      out_last_q   <= 1'b0;
    end else begin
      col_q        <= col_d;
      fill_q       <= fill_d;
      phase_q      <= phase_d;
      out_valid_q  <= out_valid_d;
      out_pixels_q <= out_pixels_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pixels = out_pixels_q;
  assign out_last   = out_last_q;

`ifdef KERNEL_WINDOW_COL_EN
  logic [COL_WIDTH-1:0] col_idx_q, col_idx_d;
  logic [COL_WIDTH-1:0] out_col_q, out_col_d;

  // Column index of the newest column; pre-increment value equals post-increment minus 1.
  always_comb begin
    col_idx_d = col_idx_q;
    out_col_d = out_col_q;
    if (accept) begin
      col_idx_d = in_last ? '0 : col_idx_q + 1'b1;
    end
    if (emit) begin
      out_col_d = col_idx_q;
    end
  end

  // Column counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_idx_q <= '0;
      out_col_q <= '0;
    end else begin
      col_idx_q <= col_idx_d;
      out_col_q <= out_col_d;
    end
  end

  assign out_col = out_col_q;
`endif

endmodule

// File: tb/tb_kernel_window.sv
// Directed bench for kernel_window: table-driven beat sequences plus hand-written
// backpressure and mid-row reset sequences. Two instances: STRIDE=1 and STRIDE=2.
module tb_kernel_window;

  localparam int unsigned BW = 3;
  localparam int unsigned BH = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [DW*BH-1:0]   in_pixels = '0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic               s1_in_ready, s2_in_ready;
  logic [BW*BH*DW-1:0] s1_out_pixels, s2_out_pixels;
  logic               s1_out_valid, s2_out_valid;
  logic               s1_out_ready = 1'b1;
  logic               s2_out_ready = 1'b1;
  logic               s1_out_last, s2_out_last;
`ifdef KERNEL_WINDOW_COL_EN
  logic [CW-1:0]      s1_out_col, s2_out_col;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  kernel_window #(
    .BLOCK_WIDTH(BW), .BLOCK_HEIGHT(BH), .DATA_WIDTH(DW), .STRIDE(1), .COL_WIDTH(CW)
  ) u_s1 (
    .clk(clk), .rst(rst), .in_pixels(in_pixels), .in_valid(in_valid), .in_last(in_last),
    .in_ready(s1_in_ready), .out_pixels(s1_out_pixels), .out_valid(s1_out_valid),
    .out_ready(s1_out_ready), .out_last(s1_out_last)
`ifdef KERNEL_WINDOW_COL_EN
    , .out_col(s1_out_col)
`endif
  );

  kernel_window #(
    .BLOCK_WIDTH(BW), .BLOCK_HEIGHT(BH), .DATA_WIDTH(DW), .STRIDE(2), .COL_WIDTH(CW)
  ) u_s2 (
    .clk(clk), .rst(rst), .in_pixels(in_pixels), .in_valid(in_valid), .in_last(in_last),
    .in_ready(s2_in_ready), .out_pixels(s2_out_pixels), .out_valid(s2_out_valid),
    .out_ready(s2_out_ready), .out_last(s2_out_last)
`ifdef KERNEL_WINDOW_COL_EN
    , .out_col(s2_out_col)
`endif
  );

  typedef struct {
    bit rst_before;
    int col;
    bit last;
    bit v1;
    bit l1;
    int ocol;
    bit v2;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Column k: row r pixel = 16*k + r.
  function automatic logic [DW*BH-1:0] col_px(input int k);
    logic [DW*BH-1:0] p;
    for (int r = 0; r < int'(BH); r++) p[r*DW +: DW] = 8'(16 * k + r);
    return p;
  endfunction

  // Window whose newest column is n: c=0..2 hold columns n-2..n.
  function automatic logic [BW*BH*DW-1:0] exp_win(input int n);
    logic [BW*BH*DW-1:0] w;
    for (int r = 0; r < int'(BH); r++)
      for (int c = 0; c < int'(BW); c++)
        w[(r*BW+c)*DW +: DW] = 8'(16 * (n - 2 + c) + r);
    return w;
  endfunction

  task automatic set_vec(input int i, input bit rb, input int col, input bit last, input bit v1,
                         input bit l1, input int oc, input bit v2);
    vecs[i].rst_before = rb;
    vecs[i].col        = col;
    vecs[i].last       = last;
    vecs[i].v1         = v1;
    vecs[i].l1         = l1;
    vecs[i].ocol       = oc;
    vecs[i].v2         = v2;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic beat(input int col, input bit last);
    in_pixels = col_px(col);
    in_last   = last;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  initial begin
    //      idx rst col last v1 l1 ocol v2
    // Continuous row of 10 beats: STRIDE=1 windows from beat 3, STRIDE=2 at 3,5,7,9.
    set_vec(0,  1,  1, 0,   0, 0, 0,   0);
    set_vec(1,  0,  2, 0,   0, 0, 0,   0);
    set_vec(2,  0,  3, 0,   1, 0, 2,   1);
    set_vec(3,  0,  4, 0,   1, 0, 3,   0);
    set_vec(4,  0,  5, 0,   1, 0, 4,   1);
    set_vec(5,  0,  6, 0,   1, 0, 5,   0);
    set_vec(6,  0,  7, 0,   1, 0, 6,   1);
    set_vec(7,  0,  8, 0,   1, 0, 7,   0);
    set_vec(8,  0,  9, 0,   1, 0, 0,   1);
    set_vec(9,  0, 10, 0,   1, 0, 1,   0);
    // Row ends on beat 4; next row restarts fill.
    set_vec(10, 1,  1, 0,   0, 0, 0,   0);
    set_vec(11, 0,  2, 0,   0, 0, 0,   0);
    set_vec(12, 0,  3, 0,   1, 0, 2,   1);
    set_vec(13, 0,  4, 1,   1, 1, 3,   0);
    set_vec(14, 0,  5, 0,   0, 0, 0,   0);
    set_vec(15, 0,  6, 0,   0, 0, 0,   0);
    set_vec(16, 0,  7, 0,   1, 0, 2,   1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {127'b0, s1_out_valid}, 128'd0);
    chk("rst_out_last", {127'b0, s1_out_last}, 128'd0);
    chk("rst_out_pixels", {56'b0, s1_out_pixels}, 128'd0);
    chk("rst_in_ready", {127'b0, s1_in_ready}, 128'd1);
`ifdef KERNEL_WINDOW_COL_EN
    chk("rst_out_col", {125'b0, s1_out_col}, 128'd0);
`endif

    // Table-driven beats, out_ready held high on both instances.
    s1_out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].rst_before) do_reset();
      chk("tbl_in_ready", {127'b0, s1_in_ready}, 128'd1);
      beat(vecs[i].col, vecs[i].last);
      chk($sformatf("tbl%0d_v1", i), {127'b0, s1_out_valid}, {127'b0, vecs[i].v1});
      if (vecs[i].v1) begin
        chk($sformatf("tbl%0d_pix1", i), {56'b0, s1_out_pixels}, {56'b0, exp_win(vecs[i].col)});
        chk($sformatf("tbl%0d_last1", i), {127'b0, s1_out_last}, {127'b0, vecs[i].l1});
`ifdef KERNEL_WINDOW_COL_EN
        chk($sformatf("tbl%0d_col1", i), {125'b0, s1_out_col}, 128'(vecs[i].ocol));
`endif
      end
      chk($sformatf("tbl%0d_v2", i), {127'b0, s2_out_valid}, {127'b0, vecs[i].v2});
      if (vecs[i].v2)
        chk($sformatf("tbl%0d_pix2", i), {56'b0, s2_out_pixels}, {56'b0, exp_win(vecs[i].col)});
    end

    // Backpressure: hold the first window for 5 cycles while a beat waits.
    do_reset();
    beat(1, 1'b0);
    beat(2, 1'b0);
    beat(3, 1'b0);
    chk("bp_first_valid", {127'b0, s1_out_valid}, 128'd1);
    chk("bp_px_1_2", {120'b0, s1_out_pixels[(1*BW+2)*DW +: DW]}, 128'h31);
    s1_out_ready = 1'b0;
    in_pixels    = col_px(4);
    in_valid     = 1'b1;
    #1;
    chk("bp_in_ready_low", {127'b0, s1_in_ready}, 128'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_ready%0d", k), {127'b0, s1_in_ready}, 128'd0);
      chk($sformatf("bp_hold_valid%0d", k), {127'b0, s1_out_valid}, 128'd1);
      chk($sformatf("bp_hold_pix%0d", k), {56'b0, s1_out_pixels}, {56'b0, exp_win(3)});
    end
    s1_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {127'b0, s1_in_ready}, 128'd1);
    @(posedge clk); #1;
    chk("bp_win4_valid", {127'b0, s1_out_valid}, 128'd1);
    chk("bp_win4_pix", {56'b0, s1_out_pixels}, {56'b0, exp_win(4)});
    in_pixels = col_px(5);
    @(posedge clk); #1;
    chk("bp_win5_pix", {56'b0, s1_out_pixels}, {56'b0, exp_win(5)});
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_drain_valid", {127'b0, s1_out_valid}, 128'd0);

    // Reset mid-row: stored columns must be discarded.
    do_reset();
    beat(1, 1'b0);
    beat(2, 1'b0);
    do_reset();
    chk("mr_out_valid", {127'b0, s1_out_valid}, 128'd0);
    chk("mr_out_pixels", {56'b0, s1_out_pixels}, 128'd0);
    chk("mr_out_last", {127'b0, s1_out_last}, 128'd0);
    beat(7, 1'b0);
    chk("mr_b1_valid", {127'b0, s1_out_valid}, 128'd0);
    beat(8, 1'b0);
    chk("mr_b2_valid", {127'b0, s1_out_valid}, 128'd0);
    beat(9, 1'b0);
    chk("mr_b3_valid", {127'b0, s1_out_valid}, 128'd1);
    chk("mr_b3_pix", {56'b0, s1_out_pixels}, {56'b0, exp_win(9)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
